// File: rtl/pipeline_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// pipeline_mem_arbiter_if
//   Bundles the two pipeline request channels (instruction fetch, data
//   memory) and the unified-memory command bus seen by pipeline_mem_arbiter.
//
// Handshake semantics (both request channels):
//   The requester raises *_req together with its address (and, for DM,
//   we/wdata) and holds *_req high until it sees the matching one-cycle
//   *_ready pulse. The arbiter samples requests only while idle, so a
//   request is accepted at the end of an idle cycle with *_req high. The
//   response data (*_rdata) is valid in the *_ready cycle and is held until
//   that requester's next completing read. A *_req still high in the
//   *_ready cycle is not a new request; it is re-evaluated in the following
//   idle cycle. The memory side has no back-pressure: mem_en is a
//   single-cycle command and mem_rdata is valid exactly MEM_LAT cycles later.
//
// Signals
//   if_req, if_addr            IF read request / address
//   if_rdata, if_ready         IF read data / completion pulse
//   dm_req, dm_we, dm_addr,
//   dm_wdata                   DM request, 1 = store, address, store data
//   dm_rdata, dm_ready         DM load data / completion pulse
//   mem_en, mem_we, mem_addr,
//   mem_wdata                  memory command strobe and registered fields
//   mem_rdata                  memory read data
//
// Modports
//   slave   the arbiter's view
//   master  the environment's view (pipeline stages plus memory)
// ---------------------------------------------------------------------------
interface pipeline_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch channel
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  // data-memory channel
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  // unified memory command bus
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ready,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ready,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// ---------------------------------------------------------------------------
// pipeline_mem_arbiter
//   Shares one single-ported memory between the pipeline's instruction-fetch
//   (IF) and data-memory (DM) stages. One access is in flight at a time:
//   grant in IDLE, a single-cycle mem_en command, wait MEM_LAT cycles for
//   mem_rdata, then a one-cycle ready pulse to the granted requester.
//   DM wins ties unless IF has been passed over STARVE_MAX consecutive times.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width
//   MEM_LAT     cycles from mem_en to valid mem_rdata (>= 1)
//   STARVE_MAX  consecutive DM grants with IF waiting before IF is forced
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous, active-low reset
//   bus             request channels and memory bus (slave modport)
//   dbg_state       current FSM state (0 IDLE, 1 BUSY_IF, 2 BUSY_DM, 3 DONE)
//   dbg_starve_cnt  current starvation count
//
// Timing of one access granted at the end of IDLE cycle T:
//   T+1          first BUSY cycle, mem_en=1, lat_cnt=0
//   T+1+MEM_LAT  mem_rdata captured, move to DONE
//   T+2+MEM_LAT  DONE: ready pulse, rdata register valid
//   T+3+MEM_LAT  back in IDLE, earliest next grant decision
// ---------------------------------------------------------------------------
module pipeline_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  localparam int SC_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_mem_arbiter_if.slave   bus,
  output logic [1:0]              dbg_state,
  output logic [SC_W-1:0]         dbg_starve_cnt
);

  localparam int LC_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  localparam logic [LC_W-1:0] LAT_LAST   = LC_W'(MEM_LAT);
  localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [LC_W-1:0]   lat_cnt;
  logic [SC_W-1:0]   starve_cnt;

  // Grant decision for the current IDLE cycle, taken from the live requests.
  logic              grant_dm;
  logic              grant_if;
  logic [ADDR_W-1:0] grant_addr;
  logic              grant_we;
  logic [DATA_W-1:0] grant_wdata;
  logic              starve_full;

  assign starve_full = (starve_cnt == STARVE_TOP);

  always_comb begin
    grant_dm    = 1'b0;
    grant_if    = 1'b0;
    grant_addr  = '0;
    grant_we    = 1'b0;
    grant_wdata = '0;
    // DM has priority except when IF is also waiting and has already been
    // passed over STARVE_MAX times in a row.
    if (bus.dm_req && !(bus.if_req && starve_full)) begin
      grant_dm    = 1'b1;
      grant_addr  = bus.dm_addr;
      grant_we    = bus.dm_we;
      grant_wdata = bus.dm_wdata;
    end else if (bus.if_req) begin
      grant_if    = 1'b1;
      grant_addr  = bus.if_addr;
      grant_we    = 1'b0;
      grant_wdata = '0;
    end
  end

  // Single registered FSM; every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      starve_cnt    <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.if_ready  <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.dm_ready  <= 1'b0;
    end else begin
      // Strobes default low so each is high for exactly one cycle.
      bus.mem_en   <= 1'b0;
      bus.if_ready <= 1'b0;
      bus.dm_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_dm || grant_if) begin
            state         <= grant_dm ? BUSY_DM : BUSY_IF;
            lat_cnt       <= '0;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= grant_we;
            bus.mem_addr  <= grant_addr;
            bus.mem_wdata <= grant_wdata;
            // Count consecutive DM grants that left IF waiting; any IF grant
            // or an uncontended DM grant restarts the count.
            if (grant_dm && bus.if_req) begin
              if (!starve_full) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end else begin
              starve_cnt <= '0;
            end
          end
        end

        BUSY_IF, BUSY_DM: begin
          if (lat_cnt == LAT_LAST) begin
            // mem_rdata is valid this cycle; capture it into the granted
            // requester's register so it is valid alongside ready.
            lat_cnt <= '0;
            state   <= DONE;
            if (state == BUSY_IF) begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_ready <= 1'b1;
            end else begin
              if (!bus.mem_we) begin
                bus.dm_rdata <= bus.mem_rdata;
              end
              bus.dm_ready <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        DONE: begin
          // Requests still high here are ignored; they are looked at again
          // in the next IDLE cycle.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pipeline_mem_arbiter
//   Bench for pipeline_mem_arbiter. Main instance uses MEM_LAT=2,
//   STARVE_MAX=2; a second instance uses MEM_LAT=1. A transaction-level
//   reference model predicts, per cycle, when the arbiter is idle, which
//   requester is granted, the command fields and the ready cycle.
// ---------------------------------------------------------------------------
module tb_pipeline_mem_arbiter;

  localparam int L0   = 2;
  localparam int L1   = 1;
  localparam int SMAX = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  pipeline_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  logic [1:0] dbg_state0, dbg_state1;
  logic [1:0] dbg_starve0, dbg_starve1;

  pipeline_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L0), .STARVE_MAX(SMAX)) u_dut0 (
    .clk(clk), .rst(rst), .bus(b0), .dbg_state(dbg_state0), .dbg_starve_cnt(dbg_starve0)
  );

  pipeline_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L1), .STARVE_MAX(SMAX)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1), .dbg_state(dbg_state1), .dbg_starve_cnt(dbg_starve1)
  );

  // ---------------- memory contents ----------------
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h8C08, ~a[15:0]};
  endfunction

  logic [31:0] mem_arr [logic [31:0]];  // memory as driven by the DUT
  logic [31:0] ref_arr [logic [31:0]];  // memory as implied by accepted requests

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : init_val(a);
  endfunction

  // Memory for instance 0: data valid exactly L0 cycles after mem_en, junk otherwise.
  int          rsp_left = 0;
  logic [31:0] rsp_val;
  always @(posedge clk) begin
    if (b0.mem_en === 1'b1) begin
      if (b0.mem_we === 1'b1) mem_arr[b0.mem_addr] = b0.mem_wdata;
      rsp_val  = mem_arr.exists(b0.mem_addr) ? mem_arr[b0.mem_addr] : init_val(b0.mem_addr);
      rsp_left = L0;
    end
    #1;
    if (rsp_left > 0) begin
      rsp_left--;
      b0.mem_rdata = (rsp_left == 0) ? rsp_val : $urandom();
    end else begin
      b0.mem_rdata = $urandom();
    end
  end

  // Memory for instance 1 (MEM_LAT=1): read-only, data in the cycle after mem_en.
  logic        hit1;
  logic [31:0] a1;
  always @(posedge clk) begin
    hit1 = (b1.mem_en === 1'b1);
    a1   = b1.mem_addr;
    #1;
    b1.mem_rdata = hit1 ? ((a1 == 32'h4) ? 32'h8C080000 : init_val(a1)) : $urandom();
  end

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int t      = 0;

  int          idle_from;     // first cycle in which the arbiter is idle
  bit          active;        // an accepted access has not yet completed
  bit          own_dm;
  int          g_cyc;
  logic [31:0] g_addr, g_wdata, g_rdata;
  bit          g_we;
  int          starve;
  logic [31:0] exp_if_rdata, exp_dm_rdata;
  logic [31:0] exp_q[$];      // expected read data of accepted reads, in order
  bit          if_done, dm_done, hold_mode, rand_mode;

  int obs_if_t, obs_dm_t, obs_act_cnt;
  bit obs_log[$];             // 1 = dm_ready seen, 0 = if_ready seen

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // One clock cycle: check outputs of cycle t, advance the model with the
  // inputs of cycle t, then move to cycle t+1 and apply requester behaviour.
  task automatic tick();
    bit e_en, e_ifr, e_dmr, pick_if;
    @(negedge clk);
    e_en  = active && (t == g_cyc + 1);
    e_ifr = active && !own_dm && (t == g_cyc + 2 + L0);
    e_dmr = active && own_dm  && (t == g_cyc + 2 + L0);
    if (e_ifr || e_dmr) begin
      if (!(e_dmr && g_we)) begin
        if (e_ifr) exp_if_rdata = exp_q.pop_front();
        else       exp_dm_rdata = exp_q.pop_front();
      end
      active  = 1'b0;
      if_done = e_ifr;
      dm_done = e_dmr;
    end
    chk("mem_en",   b0.mem_en,   e_en);
    chk("if_ready", b0.if_ready, e_ifr);
    chk("dm_ready", b0.dm_ready, e_dmr);
    if (e_en) begin
      chk("mem_addr", b0.mem_addr, g_addr);
      chk("mem_we",   b0.mem_we,   g_we);
      if (g_we) chk("mem_wdata", b0.mem_wdata, g_wdata);
    end
    chk("if_rdata", b0.if_rdata, exp_if_rdata);
    chk("dm_rdata", b0.dm_rdata, exp_dm_rdata);
    chk("state_idle", dbg_state0 == ST_IDLE, t >= idle_from);
    chk("starve_cnt", dbg_starve0, starve);

    if (b0.if_ready === 1'b1) begin obs_if_t = t; obs_log.push_back(1'b0); end
    if (b0.dm_ready === 1'b1) begin obs_dm_t = t; obs_log.push_back(1'b1); end
    if (b0.mem_en === 1'b1 || b0.if_ready === 1'b1 || b0.dm_ready === 1'b1) obs_act_cnt++;

    // Reference model at the end of cycle t.
    if (rst === 1'b0) begin
      active = 1'b0; idle_from = t + 1; starve = 0;
      exp_if_rdata = '0; exp_dm_rdata = '0; exp_q.delete();
    end else if (!active && t >= idle_from && (b0.if_req || b0.dm_req)) begin
      pick_if   = b0.if_req && (!b0.dm_req || starve == SMAX);
      active    = 1'b1;
      g_cyc     = t;
      idle_from = t + 3 + L0;
      own_dm    = !pick_if;
      if (pick_if) begin
        g_addr = b0.if_addr; g_we = 1'b0; g_wdata = '0;
        exp_q.push_back(ref_rd(b0.if_addr));
        starve = 0;
      end else begin
        g_addr = b0.dm_addr; g_we = b0.dm_we; g_wdata = b0.dm_wdata;
        if (b0.dm_we) ref_arr[b0.dm_addr] = b0.dm_wdata;
        else          exp_q.push_back(ref_rd(b0.dm_addr));
        starve = b0.if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
      end
    end

    @(posedge clk); #1;
    t++;
    if (if_done && !hold_mode) b0.if_req = 1'b0;
    if (dm_done && !hold_mode) b0.dm_req = 1'b0;
    if_done = 1'b0;
    dm_done = 1'b0;
    if (rand_mode) begin
      if (!b0.if_req && $urandom_range(0, 2) == 0) begin
        b0.if_req = 1'b1; b0.if_addr = rand_addr();
      end else if (b0.if_req && active && !own_dm && $urandom_range(0, 1) == 1) begin
        b0.if_addr = $urandom();
      end
      if (!b0.dm_req && $urandom_range(0, 2) == 0) begin
        b0.dm_req = 1'b1; b0.dm_we = 1'($urandom_range(0, 1));
        b0.dm_addr = rand_addr(); b0.dm_wdata = $urandom();
      end else if (b0.dm_req && active && own_dm && $urandom_range(0, 1) == 1) begin
        b0.dm_addr = $urandom(); b0.dm_wdata = $urandom(); b0.dm_we = ~b0.dm_we;
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((active || b0.if_req || b0.dm_req || t < idle_from) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_in_budget"}, n < budget, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t0, t1, n, rdy_k, en_k;
    logic [31:0] rd1, en_addr;
    bit pat [6];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b0;
    b0.if_req = 1'b0; b0.if_addr = '0;
    b0.dm_req = 1'b0; b0.dm_we = 1'b0; b0.dm_addr = '0; b0.dm_wdata = '0;
    b1.if_req = 1'b0; b1.if_addr = '0;
    b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dm_addr = '0; b1.dm_wdata = '0;
    mem_arr[32'h4] = 32'h8C080000;
    ref_arr[32'h4] = 32'h8C080000;
    active = 1'b0; idle_from = 0; starve = 0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    hold_mode = 1'b0; rand_mode = 1'b0; if_done = 1'b0; dm_done = 1'b0;
    obs_if_t = -1; obs_dm_t = -1; obs_act_cnt = 0;

    @(posedge clk); #1;
    repeat (3) tick();
    chk("rst_mem_en",    b0.mem_en,    1'b0);
    chk("rst_mem_addr",  b0.mem_addr,  32'h0);
    chk("rst_if_rdata",  b0.if_rdata,  32'h0);
    chk("rst_dm_ready",  b0.dm_ready,  1'b0);
    rst = 1'b1;
    tick();

    // Test 1: IF only.
    t0 = t; b0.if_req = 1'b1; b0.if_addr = 32'h4;
    wait_idle(20, "t1");
    chk("t1_ready_cycle", obs_if_t - t0, 4);
    chk("t1_if_rdata", b0.if_rdata, 32'h8C080000);

    // Test 2: both request together, DM first then IF.
    t0 = t;
    b0.dm_req = 1'b1; b0.dm_we = 1'b0; b0.dm_addr = 32'h10;
    b0.if_req = 1'b1; b0.if_addr = 32'h8;
    wait_idle(40, "t2");
    chk("t2_dm_ready_cycle", obs_dm_t - t0, 4);
    chk("t2_if_ready_cycle", obs_if_t - t0, 9);

    // Test 3: store leaves dm_rdata alone, then read back.
    b0.dm_req = 1'b1; b0.dm_we = 1'b1; b0.dm_addr = 32'h10; b0.dm_wdata = 32'hDEADBEEF;
    wait_idle(20, "t3s");
    chk("t3_dm_rdata_held", b0.dm_rdata, init_val(32'h10));
    b0.dm_req = 1'b1; b0.dm_we = 1'b0; b0.dm_addr = 32'h10;
    wait_idle(20, "t3l");
    chk("t3_readback", b0.dm_rdata, 32'hDEADBEEF);

    // Test 4: starvation with both requests held.
    obs_log.delete(); hold_mode = 1'b1;
    b0.if_req = 1'b1; b0.if_addr = 32'hC;
    b0.dm_req = 1'b1; b0.dm_we = 1'b0; b0.dm_addr = 32'h14;
    n = 0;
    while (obs_log.size() < 6 && n < 80) begin tick(); n++; end
    chk("t4_six_grants", n < 80, 1'b1);
    b0.if_req = 1'b0; b0.dm_req = 1'b0; hold_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < obs_log.size()) chk($sformatf("t4_order_%0d", i), obs_log[i], pat[i]);
    end
    wait_idle(20, "t4");
    chk("t4_starve_cleared", dbg_starve0, 2'd0);

    // Test 6: idle for 50 cycles.
    obs_act_cnt = 0;
    repeat (50) tick();
    chk("t6_no_activity", obs_act_cnt, 0);

    // Test 5: reset in cycle 2 of a DM load.
    t0 = t; obs_dm_t = -1;
    b0.dm_req = 1'b1; b0.dm_we = 1'b0; b0.dm_addr = 32'h20;
    tick(); tick();
    rst = 1'b0; b0.dm_req = 1'b0;
    tick();
    rst = 1'b1;
    chk("t5_mem_en",    b0.mem_en,    1'b0);
    chk("t5_mem_we",    b0.mem_we,    1'b0);
    chk("t5_mem_addr",  b0.mem_addr,  32'h0);
    chk("t5_mem_wdata", b0.mem_wdata, 32'h0);
    chk("t5_if_rdata",  b0.if_rdata,  32'h0);
    chk("t5_dm_rdata",  b0.dm_rdata,  32'h0);
    chk("t5_state",     dbg_state0,   ST_IDLE);
    t1 = t; b0.if_req = 1'b1; b0.if_addr = 32'h8;
    wait_idle(30, "t5");
    chk("t5_no_dm_ready", obs_dm_t, -1);
    chk("t5_if_ready_cycle", obs_if_t - t1, L0 + 2);

    // Random traffic against the reference model.
    rand_mode = 1'b1;
    repeat (400) tick();
    rand_mode = 1'b0;
    wait_idle(80, "rand");

    // MEM_LAT=1 instance: IF only, ready in cycle 3.
    b1.if_req = 1'b1; b1.if_addr = 32'h4;
    rdy_k = -1; en_k = -1; rd1 = '0; en_addr = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b1.mem_en === 1'b1 && en_k < 0) begin en_k = k; en_addr = b1.mem_addr; end
      if (b1.if_ready === 1'b1 && rdy_k < 0) begin rdy_k = k; rd1 = b1.if_rdata; end
      @(posedge clk); #1;
      if (rdy_k >= 0) b1.if_req = 1'b0;
    end
    chk("lat1_mem_en_cycle", en_k, 1);
    chk("lat1_mem_addr", en_addr, 32'h4);
    chk("lat1_ready_cycle", rdy_k, 3);
    chk("lat1_if_rdata", rd1, 32'h8C080000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
